// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station.
// Holds dispatched micro-ops, wakes them from the CDB and issues the oldest ready one.
module alu_rs #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [3:0]                         disp_alu_op,
    input  logic [TAG_W-1:0]                   disp_rob_tag,
    input  logic                               disp_src1_rdy,
    input  logic [31:0]                        disp_src1_val,
    input  logic [TAG_W-1:0]                   disp_src1_tag,
    input  logic                               disp_src2_rdy,
    input  logic [31:0]                        disp_src2_val,
    input  logic [TAG_W-1:0]                   disp_src2_tag,
    input  logic                               cdb_valid,
    input  logic [TAG_W-1:0]                   cdb_tag,
    input  logic [31:0]                        cdb_data,
    output logic                               iss_valid,
    input  logic                               iss_ready,
    output logic [31:0]                        iss_operand_a,
    output logic [31:0]                        iss_operand_b,
    output logic [3:0]                         iss_alu_op,
    output logic [TAG_W-1:0]                   iss_rob_tag,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   rs_count
);

    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int AW = $clog2(NUM_ENTRIES);

    // Per-entry state. age is the number of valid entries older than this one,
    // so ages of valid entries are unique and 0 marks the oldest.
    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] s1_rdy;
    logic [NUM_ENTRIES-1:0] s2_rdy;
    logic [3:0]             op      [NUM_ENTRIES];
    logic [TAG_W-1:0]       rob_tag [NUM_ENTRIES];
    logic [TAG_W-1:0]       s1_tag  [NUM_ENTRIES];
    logic [TAG_W-1:0]       s2_tag  [NUM_ENTRIES];
    logic [31:0]            s1_val  [NUM_ENTRIES];
    logic [31:0]            s2_val  [NUM_ENTRIES];
    logic [AW-1:0]          age     [NUM_ENTRIES];

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [AW-1:0] sel_age;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          disp_fire;
    logic          iss_fire;
    logic [AW-1:0] new_age;
    logic          byp1;
    logic          byp2;

    // Select the oldest entry whose operands are both ready.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid[i] && s1_rdy[i] && s2_rdy[i] &&
                (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = age[i];
            end
        end
    end

    // Find the lowest-index free slot from registered occupancy.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Handshakes, dispatch bypass and the age given to a new entry.
    always_comb begin
        disp_ready = (rs_count < CW'(NUM_ENTRIES));
        disp_fire  = disp_valid && disp_ready && !flush;
        iss_fire   = sel_found && iss_ready && !flush;
        new_age    = AW'(rs_count - CW'(iss_fire));
        byp1       = !disp_src1_rdy && cdb_valid &&
                     (cdb_tag == disp_src1_tag);
        byp2       = !disp_src2_rdy && cdb_valid &&
                     (cdb_tag == disp_src2_tag);
    end

    // Issue outputs come from registered state only and read zero when idle.
    always_comb begin
        iss_valid     = sel_found;
        iss_operand_a = '0;
        iss_operand_b = '0;
        iss_alu_op    = '0;
        iss_rob_tag   = '0;
        if (sel_found) begin
            iss_operand_a = s1_val[sel_idx];
            iss_operand_b = s2_val[sel_idx];
            iss_alu_op    = op[sel_idx];
            iss_rob_tag   = rob_tag[sel_idx];
        end
    end

    // Occupancy counter; flush and reset empty the station.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rs_count <= '0;
        end else begin
            rs_count <= rs_count + CW'(disp_fire) - CW'(iss_fire);
        end
    end

    // Valid bits: clear on issue, set on dispatch into the free slot.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid <= '0;
        end else begin
            if (iss_fire) begin
                valid[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                valid[free_idx] <= 1'b1;
            end
        end
    end

    // Ages close the gap left by an issued entry; new entries go to the back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age[i] <= '0;
            end
        end else if (!flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid[i] && iss_fire && age[i] > sel_age) begin
                    age[i] <= age[i] - AW'(1);
                end
            end
            if (disp_fire) begin
                age[free_idx] <= new_age;
            end
        end
    end

    // Operand capture: CDB wakeup of waiting sources, then dispatch write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_rdy <= '0;
            s2_rdy <= '0;
        end else if (!flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid[i] && cdb_valid && !s1_rdy[i] &&
                    s1_tag[i] == cdb_tag) begin
                    s1_rdy[i] <= 1'b1;
                    s1_val[i] <= cdb_data;
                end
                if (valid[i] && cdb_valid && !s2_rdy[i] &&
                    s2_tag[i] == cdb_tag) begin
                    s2_rdy[i] <= 1'b1;
                    s2_val[i] <= cdb_data;
                end
            end
            if (disp_fire) begin
                op[free_idx]      <= disp_alu_op;
                rob_tag[free_idx] <= disp_rob_tag;
                s1_tag[free_idx]  <= disp_src1_tag;
                s2_tag[free_idx]  <= disp_src2_tag;
                s1_rdy[free_idx]  <= disp_src1_rdy || byp1;
                s2_rdy[free_idx]  <= disp_src2_rdy || byp2;
                s1_val[free_idx]  <= byp1 ? cdb_data : disp_src1_val;
                s2_val[free_idx]  <= byp2 ? cdb_data : disp_src2_val;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs.
// Expected values are hand-computed per vector.
module tb_alu_rs;

    localparam int N  = 4;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          disp_valid;
    logic          disp_ready;
    logic [3:0]    disp_alu_op;
    logic [TW-1:0] disp_rob_tag;
    logic          disp_src1_rdy;
    logic [31:0]   disp_src1_val;
    logic [TW-1:0] disp_src1_tag;
    logic          disp_src2_rdy;
    logic [31:0]   disp_src2_val;
    logic [TW-1:0] disp_src2_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          iss_valid;
    logic          iss_ready;
    logic [31:0]   iss_operand_a;
    logic [31:0]   iss_operand_b;
    logic [3:0]    iss_alu_op;
    logic [TW-1:0] iss_rob_tag;
    logic [2:0]    rs_count;

    int n_cmp = 0;
    int n_err = 0;

    alu_rs #(.NUM_ENTRIES(N), .TAG_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_alu_op   (disp_alu_op),
        .disp_rob_tag  (disp_rob_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src1_val (disp_src1_val),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src2_val (disp_src2_val),
        .disp_src2_tag (disp_src2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_operand_a (iss_operand_a),
        .iss_operand_b (iss_operand_b),
        .iss_alu_op    (iss_alu_op),
        .iss_rob_tag   (iss_rob_tag),
        .rs_count      (rs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_alu_op   = '0;
        disp_rob_tag  = '0;
        disp_src1_rdy = 1'b0;
        disp_src1_val = '0;
        disp_src1_tag = '0;
        disp_src2_rdy = 1'b0;
        disp_src2_val = '0;
        disp_src2_tag = '0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_data      = '0;
    endtask

    task automatic disp(input logic [3:0] o, input logic [TW-1:0] rt,
                        input logic r1, input logic [31:0] v1,
                        input logic [TW-1:0] t1,
                        input logic r2, input logic [31:0] v2,
                        input logic [TW-1:0] t2);
        disp_valid    = 1'b1;
        disp_alu_op   = o;
        disp_rob_tag  = rt;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_src2_tag = t2;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        idle();
        iss_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        check("rst_count", 32'(rs_count), 0);
        check("rst_dready", 32'(disp_ready), 1);
        check("rst_ivalid", 32'(iss_valid), 0);
        check("rst_a", iss_operand_a, 0);
        check("rst_tag", 32'(iss_rob_tag), 0);
        rst_n = 1'b1;

        // simple ADD 5+7
        iss_ready = 1'b1;
        disp(4'd0, 4'd3, 1, 32'd5, 0, 1, 32'd7, 0);
        step();
        idle();
        check("add_valid", 32'(iss_valid), 1);
        check("add_a", iss_operand_a, 5);
        check("add_b", iss_operand_b, 7);
        check("add_op", 32'(iss_alu_op), 0);
        check("add_tag", 32'(iss_rob_tag), 3);
        check("add_cnt1", 32'(rs_count), 1);
        step();
        check("add_cnt0", 32'(rs_count), 0);
        check("add_idle", 32'(iss_valid), 0);

        // wakeup via CDB
        disp(4'd1, 4'd4, 0, 32'hdead, 4'd2, 1, 32'd1, 0);
        step();
        idle();
        check("wk_wait", 32'(iss_valid), 0);
        cdb(4'd2, 32'h10);
        step();
        idle();
        check("wk_valid", 32'(iss_valid), 1);
        check("wk_a", iss_operand_a, 32'h10);
        check("wk_b", iss_operand_b, 1);
        check("wk_op", 32'(iss_alu_op), 1);
        step();
        check("wk_cnt", 32'(rs_count), 0);

        // dispatch bypass
        disp(4'd1, 4'd4, 0, 32'hdead, 4'd2, 1, 32'd1, 0);
        cdb(4'd2, 32'h10);
        step();
        idle();
        check("byp_valid", 32'(iss_valid), 1);
        check("byp_a", iss_operand_a, 32'h10);
        check("byp_b", iss_operand_b, 1);
        step();
        check("byp_cnt", 32'(rs_count), 0);

        // age order: A pending, B and C ready
        disp(4'd2, 4'd5, 0, 0, 4'd5, 1, 32'd2, 0);
        step();
        disp(4'd3, 4'd6, 1, 32'h20, 0, 1, 32'd3, 0);
        step();
        check("age_B", 32'(iss_rob_tag), 6);
        check("age_Ba", iss_operand_a, 32'h20);
        disp(4'd4, 4'd7, 1, 32'h30, 0, 1, 32'd4, 0);
        step();
        idle();
        check("age_C", 32'(iss_rob_tag), 7);
        step();
        check("age_Anr", 32'(iss_valid), 0);
        check("age_cnt1", 32'(rs_count), 1);
        cdb(4'd5, 32'h55);
        step();
        idle();
        check("age_A", 32'(iss_rob_tag), 5);
        check("age_Aa", iss_operand_a, 32'h55);
        step();
        check("age_cnt0", 32'(rs_count), 0);

        // out-of-index age: re-dispatch into entry 0 behind older entry 1
        iss_ready = 1'b0;
        disp(4'd5, 4'd8, 1, 32'h8, 0, 1, 32'h8, 0);
        step();
        disp(4'd6, 4'd9, 0, 0, 4'd1, 1, 32'h9, 0);
        step();
        idle();
        check("oi_X", 32'(iss_rob_tag), 8);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        check("oi_Ywait", 32'(iss_valid), 0);
        check("oi_cnt1", 32'(rs_count), 1);
        disp(4'd7, 4'd10, 1, 32'ha, 0, 1, 32'ha, 0);
        step();
        idle();
        check("oi_Z", 32'(iss_rob_tag), 10);
        cdb(4'd1, 32'h99);
        step();
        idle();
        check("oi_Yold", 32'(iss_rob_tag), 9);
        check("oi_Ya", iss_operand_a, 32'h99);
        iss_ready = 1'b1;
        step();
        check("oi_Zlast", 32'(iss_rob_tag), 10);
        step();
        check("oi_cnt0", 32'(rs_count), 0);

        // fill with backpressure
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(4'd9, 4'(11 + i), 1, 32'(32'h100 + i), 0, 1, 32'h1, 0);
            step();
        end
        idle();
        check("full_dready", 32'(disp_ready), 0);
        check("full_cnt", 32'(rs_count), 4);
        check("full_tag", 32'(iss_rob_tag), 11);
        step();
        check("hold_tag", 32'(iss_rob_tag), 11);
        check("hold_a", iss_operand_a, 32'h100);
        check("hold_valid", 32'(iss_valid), 1);
        // issue while full: concurrent dispatch must be refused
        iss_ready = 1'b1;
        disp(4'd0, 4'd15, 1, 32'hf, 0, 1, 32'hf, 0);
        step();
        idle();
        iss_ready = 1'b0;
        check("bp_dready", 32'(disp_ready), 1);
        check("bp_cnt", 32'(rs_count), 3);
        check("bp_next", 32'(iss_rob_tag), 12);

        // flush collision with 3 entries
        check("fl_pre", 32'(iss_valid), 1);
        flush     = 1'b1;
        iss_ready = 1'b1;
        disp(4'd0, 4'd15, 1, 32'hf, 0, 1, 32'hf, 0);
        cdb(4'd3, 32'h77);
        step();
        idle();
        check("fl_cnt", 32'(rs_count), 0);
        check("fl_ivalid", 32'(iss_valid), 0);
        check("fl_dready", 32'(disp_ready), 1);
        step();
        check("fl_absent", 32'(iss_valid), 0);
        check("fl_cnt2", 32'(rs_count), 0);

        // reset mid-operation
        iss_ready = 1'b0;
        disp(4'd0, 4'd2, 1, 32'h2, 0, 1, 32'h2, 0);
        step();
        check("mr_cnt1", 32'(rs_count), 1);
        rst_n     = 1'b0;
        iss_ready = 1'b1;
        cdb(4'd2, 32'h3);
        step();
        idle();
        check("mr_cnt", 32'(rs_count), 0);
        check("mr_ivalid", 32'(iss_valid), 0);
        check("mr_dready", 32'(disp_ready), 1);
        check("mr_a", iss_operand_a, 0);
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
